// File: rtl/st7735_spi_decoder.sv
// ST7735 receive-side model: synchronised 4-wire SPI slave, byte deserialiser and
// command parser that turns RAMWR data into addressed RGB565 pixel writes.
//
// state   | meaning
// P_IDLE  | no command in progress; data bytes ignored
// P_CASET | collecting 4 column-window argument bytes
// P_RASET | collecting 4 row-window argument bytes
// P_RAMWR | pairing data bytes into pixels, advancing the cursor
// P_SKIP  | unsupported command; its arguments are ignored
module st7735_spi_decoder #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 80,
  parameter int X_OFFSET    = 1,
  parameter int Y_OFFSET    = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic        SYSTEM_CLK,
  input  logic        SYSTEM_RST,
  input  logic        LCD_CLK,
  input  logic        CS,
  input  logic        MOSI,
  input  logic        DC,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_cmd,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_color,
  output logic        pix_in_view,
  output logic        frame_done,
  output logic        sleep_out,
  output logic        display_on,
  output logic        inverted
);

  localparam logic [15:0] X_LO = 16'(X_OFFSET);
  localparam logic [15:0] X_HI = 16'(X_OFFSET + WIDTH - 1);
  localparam logic [15:0] Y_LO = 16'(Y_OFFSET);
  localparam logic [15:0] Y_HI = 16'(Y_OFFSET + HEIGHT - 1);

  typedef enum logic [2:0] {P_IDLE, P_CASET, P_RASET, P_RAMWR, P_SKIP} pstate_t;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync, dc_sync;
  logic                   clk_s, cs_s, mosi_s, dc_s;
  logic                   clk_prev;
  logic                   clk_rise;
  logic [2:0]             bit_cnt;
  logic [6:0]             sr;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign clk_rise = ~clk_prev & clk_s;

  // CS syncs reset to the deselected level so no phantom edge is counted after reset
  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RST) begin
      clk_sync    <= '0;
      cs_sync     <= '1;
      mosi_sync   <= '0;
      dc_sync     <= '0;
      clk_prev    <= 1'b0;
      bit_cnt     <= 3'd0;
      sr          <= 7'd0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'd0;
      byte_is_cmd <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], LCD_CLK};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      dc_sync    <= {dc_sync[SYNC_STAGES-2:0], DC};
      clk_prev   <= clk_s;
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= 3'd0;
      end else if (clk_rise) begin
        sr      <= {sr[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid  <= 1'b1;
          byte_data   <= {sr, mosi_s};
          byte_is_cmd <= ~dc_s;
        end
      end
    end
  end

  pstate_t     state, state_nxt;
  logic [1:0]  arg_idx, arg_idx_nxt;
  logic [23:0] arg_buf, arg_buf_nxt;
  logic [15:0] xs, xe, ys, ye, xs_nxt, xe_nxt, ys_nxt, ye_nxt;
  logic [15:0] cur_x, cur_y, cur_x_nxt, cur_y_nxt;
  logic [7:0]  msb, msb_nxt;
  logic        msb_pend, msb_pend_nxt;
  logic        pix_valid_nxt, pix_in_view_nxt, frame_done_nxt;
  logic [15:0] pix_x_nxt, pix_y_nxt, pix_color_nxt;
  logic        sleep_nxt, disp_nxt, inv_nxt;
  logic        cur_in_view;

  assign cur_in_view = (cur_x >= X_LO) && (cur_x <= X_HI) && (cur_y >= Y_LO) && (cur_y <= Y_HI);

  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RST) begin
      state       <= P_IDLE;
      arg_idx     <= 2'd0;
      arg_buf     <= 24'd0;
      xs          <= 16'd0;
      xe          <= X_HI;
      ys          <= 16'd0;
      ye          <= Y_HI;
      cur_x       <= 16'd0;
      cur_y       <= 16'd0;
      msb         <= 8'd0;
      msb_pend    <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 16'd0;
      pix_y       <= 16'd0;
      pix_color   <= 16'd0;
      pix_in_view <= 1'b0;
      frame_done  <= 1'b0;
      sleep_out   <= 1'b0;
      display_on  <= 1'b0;
      inverted    <= 1'b0;
    end else begin
      state       <= state_nxt;
      arg_idx     <= arg_idx_nxt;
      arg_buf     <= arg_buf_nxt;
      xs          <= xs_nxt;
      xe          <= xe_nxt;
      ys          <= ys_nxt;
      ye          <= ye_nxt;
      cur_x       <= cur_x_nxt;
      cur_y       <= cur_y_nxt;
      msb         <= msb_nxt;
      msb_pend    <= msb_pend_nxt;
      pix_valid   <= pix_valid_nxt;
      pix_x       <= pix_x_nxt;
      pix_y       <= pix_y_nxt;
      pix_color   <= pix_color_nxt;
      pix_in_view <= pix_in_view_nxt;
      frame_done  <= frame_done_nxt;
      sleep_out   <= sleep_nxt;
      display_on  <= disp_nxt;
      inverted    <= inv_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    arg_idx_nxt     = arg_idx;
    arg_buf_nxt     = arg_buf;
    xs_nxt          = xs;
    xe_nxt          = xe;
    ys_nxt          = ys;
    ye_nxt          = ye;
    cur_x_nxt       = cur_x;
    cur_y_nxt       = cur_y;
    msb_nxt         = msb;
    msb_pend_nxt    = msb_pend;
    pix_valid_nxt   = 1'b0;
    pix_x_nxt       = pix_x;
    pix_y_nxt       = pix_y;
    pix_color_nxt   = pix_color;
    pix_in_view_nxt = pix_in_view;
    frame_done_nxt  = 1'b0;
    sleep_nxt       = sleep_out;
    disp_nxt        = display_on;
    inv_nxt         = inverted;

    if (byte_valid && byte_is_cmd) begin
      arg_idx_nxt = 2'd0;
      state_nxt   = P_SKIP;
      case (byte_data)
        8'h2A: state_nxt = P_CASET;
        8'h2B: state_nxt = P_RASET;
        8'h2C: begin
          state_nxt    = P_RAMWR;
          cur_x_nxt    = xs;
          cur_y_nxt    = ys;
          msb_pend_nxt = 1'b0;
        end
        8'h10: begin sleep_nxt = 1'b0; state_nxt = P_IDLE; end
        8'h11: begin sleep_nxt = 1'b1; state_nxt = P_IDLE; end
        8'h20: begin inv_nxt   = 1'b0; state_nxt = P_IDLE; end
        8'h21: begin inv_nxt   = 1'b1; state_nxt = P_IDLE; end
        8'h28: begin disp_nxt  = 1'b0; state_nxt = P_IDLE; end
        8'h29: begin disp_nxt  = 1'b1; state_nxt = P_IDLE; end
        default: ;
      endcase
    end else if (byte_valid) begin
      case (state)
        P_CASET, P_RASET: begin
          arg_idx_nxt = arg_idx + 2'd1;
          case (arg_idx)
            2'd0: arg_buf_nxt[23:16] = byte_data;
            2'd1: arg_buf_nxt[15:8]  = byte_data;
            2'd2: arg_buf_nxt[7:0]   = byte_data;
            default: begin
              // window only changes once all four arguments have arrived
              if (state == P_CASET) begin
                xs_nxt = arg_buf[23:8];
                xe_nxt = {arg_buf[7:0], byte_data};
              end else begin
                ys_nxt = arg_buf[23:8];
                ye_nxt = {arg_buf[7:0], byte_data};
              end
              state_nxt = P_IDLE;
            end
          endcase
        end
        P_RAMWR: begin
          if (!msb_pend) begin
            msb_nxt      = byte_data;
            msb_pend_nxt = 1'b1;
          end else begin
            pix_valid_nxt   = 1'b1;
            pix_x_nxt       = cur_x;
            pix_y_nxt       = cur_y;
            pix_color_nxt   = {msb, byte_data};
            pix_in_view_nxt = cur_in_view;
            msb_pend_nxt    = 1'b0;
            if (cur_x == xe) begin
              cur_x_nxt = xs;
              if (cur_y == ye) begin
                cur_y_nxt      = ys;
                frame_done_nxt = 1'b1;
              end else begin
                cur_y_nxt = cur_y + 16'd1;
              end
            end else begin
              cur_x_nxt = cur_x + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_st7735_spi_decoder.sv
// Scoreboard bench for st7735_spi_decoder: directed scenarios plus a random command
// stream, checked against a transaction-level display-controller model.
module tb_st7735_spi_decoder;

  logic        SYSTEM_CLK = 1'b0;
  logic        SYSTEM_RST = 1'b1;
  logic        LCD_CLK = 1'b0;
  logic        CS = 1'b1;
  logic        MOSI = 1'b0;
  logic        DC = 1'b0;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_is_cmd;
  logic        pix_valid;
  logic [15:0] pix_x, pix_y, pix_color;
  logic        pix_in_view, frame_done, sleep_out, display_on, inverted;

  st7735_spi_decoder dut (
    .SYSTEM_CLK(SYSTEM_CLK), .SYSTEM_RST(SYSTEM_RST), .LCD_CLK(LCD_CLK), .CS(CS),
    .MOSI(MOSI), .DC(DC), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_is_cmd(byte_is_cmd), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .pix_in_view(pix_in_view), .frame_done(frame_done),
    .sleep_out(sleep_out), .display_on(display_on), .inverted(inverted)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  typedef struct {
    logic [7:0] data;
    logic       is_cmd;
    logic [2:0] flags;
  } byte_exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] color;
    logic        in_view;
    logic        fd;
  } pix_exp_t;

  byte_exp_t byte_q[$];
  pix_exp_t  pix_q[$];

  int checks = 0;
  int errors = 0;
  logic rst_chk = 1'b0;
  logic end_req = 1'b0;

  // ---------------- reference model ----------------
  typedef enum {M_NONE, M_COLS, M_ROWS, M_PIXELS} mode_t;
  mode_t       m_mode;
  logic [7:0]  m_args[$];
  int          m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
  bit          m_have_msb;
  logic [7:0]  m_msb;
  bit          m_sleep, m_disp, m_inv;

  task automatic model_reset();
    m_mode = M_NONE; m_args.delete();
    m_xs = 0; m_xe = 160; m_ys = 0; m_ye = 105; m_cx = 0; m_cy = 0;
    m_have_msb = 0; m_msb = 8'h00;
    m_sleep = 0; m_disp = 0; m_inv = 0;
  endtask

  task automatic model_byte(input bit is_cmd, input logic [7:0] b);
    byte_exp_t be;
    pix_exp_t  pe;
    if (is_cmd) begin
      m_args.delete();
      m_mode = M_NONE;
      case (b)
        8'h2A: m_mode = M_COLS;
        8'h2B: m_mode = M_ROWS;
        8'h2C: begin m_mode = M_PIXELS; m_cx = m_xs; m_cy = m_ys; m_have_msb = 0; end
        8'h10: m_sleep = 0;
        8'h11: m_sleep = 1;
        8'h20: m_inv = 0;
        8'h21: m_inv = 1;
        8'h28: m_disp = 0;
        8'h29: m_disp = 1;
        default: ;
      endcase
    end else if (m_mode == M_COLS || m_mode == M_ROWS) begin
      m_args.push_back(b);
      if (m_args.size() == 4) begin
        if (m_mode == M_COLS) begin
          m_xs = m_args[0] * 256 + m_args[1]; m_xe = m_args[2] * 256 + m_args[3];
        end else begin
          m_ys = m_args[0] * 256 + m_args[1]; m_ye = m_args[2] * 256 + m_args[3];
        end
        m_args.delete();
        m_mode = M_NONE;
      end
    end else if (m_mode == M_PIXELS) begin
      if (!m_have_msb) begin
        m_msb = b; m_have_msb = 1;
      end else begin
        m_have_msb = 0;
        pe.x = 16'(m_cx); pe.y = 16'(m_cy); pe.color = {m_msb, b};
        pe.in_view = (m_cx >= 1 && m_cx <= 160 && m_cy >= 26 && m_cy <= 105);
        pe.fd = (m_cx == m_xe && m_cy == m_ye);
        pix_q.push_back(pe);
        if (m_cx == m_xe) begin
          m_cx = m_xs;
          m_cy = (m_cy == m_ye) ? m_ys : (m_cy + 1) % 65536;
        end else begin
          m_cx = (m_cx + 1) % 65536;
        end
      end
    end
    be.data = b; be.is_cmd = is_cmd; be.flags = {m_sleep, m_disp, m_inv};
    byte_q.push_back(be);
  endtask

  // ---------------- stimulus ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge SYSTEM_CLK);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      wait_clks(4);
      LCD_CLK = 1'b1;
      wait_clks(4);
      LCD_CLK = 1'b0;
    end
  endtask

  task automatic spi_byte(input bit is_cmd, input logic [7:0] b);
    model_byte(is_cmd, b);
    CS = 1'b0; DC = ~is_cmd;
    wait_clks(2);
    spi_bits(b, 8);
    wait_clks(2);
    CS = 1'b1;
    wait_clks(4);
  endtask

  task automatic cmd4(input logic [7:0] c, input int s, input int e);
    spi_byte(1, c);
    spi_byte(0, 8'(s >> 8)); spi_byte(0, 8'(s));
    spi_byte(0, 8'(e >> 8)); spi_byte(0, 8'(e));
  endtask

  task automatic do_reset();
    SYSTEM_RST = 1'b1;
    model_reset();
    wait_clks(1);
    rst_chk = 1'b1;
    wait_clks(3);
    rst_chk = 1'b0;
    SYSTEM_RST = 1'b0;
    wait_clks(2);
  endtask

  initial begin
    int r, n, s;
    model_reset();
    wait_clks(1);
    rst_chk = 1'b1;
    wait_clks(3);
    rst_chk = 1'b0;
    SYSTEM_RST = 1'b0;
    wait_clks(4);

    spi_byte(1, 8'h11);                                   // sleep out
    cmd4(8'h2A, 1, 160); cmd4(8'h2B, 26, 105);            // full visible window
    spi_byte(1, 8'h2C);
    spi_byte(0, 8'hF8); spi_byte(0, 8'h00); spi_byte(0, 8'h07); spi_byte(0, 8'hE0);

    cmd4(8'h2A, 5, 6); cmd4(8'h2B, 7, 8);                 // 2x2 window, wraps once
    spi_byte(1, 8'h2C);
    for (int i = 0; i < 10; i++) spi_byte(0, 8'($urandom));

    CS = 1'b0; DC = 1'b1; wait_clks(2);                   // aborted partial byte
    spi_bits(8'hA5, 5);
    wait_clks(2); CS = 1'b1; wait_clks(8);
    spi_byte(1, 8'h29);

    spi_byte(1, 8'h2A); spi_byte(0, 8'h00); spi_byte(0, 8'h03);
    spi_byte(1, 8'h2C); spi_byte(0, 8'h12); spi_byte(0, 8'h34);

    spi_byte(1, 8'h21);
    spi_byte(1, 8'h2C); spi_byte(0, 8'hAB);               // reset with an MSB pending
    wait_clks(10);
    do_reset();
    spi_byte(0, 8'h55); spi_byte(0, 8'h66); spi_byte(0, 8'h77);
    spi_byte(1, 8'h2C); spi_byte(0, 8'h01); spi_byte(0, 8'h02);

    for (int k = 0; k < 70; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: begin
          s = $urandom_range(0, 200);
          cmd4((r < 2) ? 8'h2A : 8'h2B, s, s + $urandom_range(0, 3));
        end
        4: begin
          spi_byte(1, ($urandom_range(0, 1) == 0) ? 8'h2A : 8'h2B);
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) spi_byte(0, 8'($urandom));
        end
        5: begin
          n = $urandom_range(0, 5);
          case (n)
            0: spi_byte(1, 8'h10); 1: spi_byte(1, 8'h11); 2: spi_byte(1, 8'h20);
            3: spi_byte(1, 8'h21); 4: spi_byte(1, 8'h28); default: spi_byte(1, 8'h29);
          endcase
        end
        6: begin
          spi_byte(1, ($urandom_range(0, 1) == 0) ? 8'h36 : 8'h3A);
          n = $urandom_range(0, 2);
          for (int i = 0; i < n; i++) spi_byte(0, 8'($urandom));
        end
        default: begin
          spi_byte(1, 8'h2C);
          n = $urandom_range(2, 18);
          for (int i = 0; i < n; i++) spi_byte(0, 8'($urandom));
        end
      endcase
    end
    wait_clks(20);
    end_req = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] flag_exp;
  bit         flag_pend = 0;
  byte_exp_t  be_m;
  pix_exp_t   pe_m;
  logic [63:0] all_out;
  assign all_out = {byte_valid, byte_data, byte_is_cmd, pix_valid, pix_x, pix_y, pix_color,
                    pix_in_view, frame_done, sleep_out, display_on, inverted};

  always @(negedge SYSTEM_CLK) begin
    if (end_req) begin
      checks++;
      if (byte_q.size() != 0) begin
        errors++; $display("FAIL byte_q_drain: %0d bytes still expected, required 0", byte_q.size());
      end
      checks++;
      if (pix_q.size() != 0) begin
        errors++; $display("FAIL pix_q_drain: %0d pixels still expected, required 0", pix_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (rst_chk) begin
      flag_pend = 0;
      checks++;
      if (all_out != 64'd0) begin
        errors++; $display("FAIL reset_outputs: got %h required 0", all_out);
      end
    end else if (!SYSTEM_RST) begin
      if (flag_pend) begin
        flag_pend = 0;
        checks++;
        if ({sleep_out, display_on, inverted} != flag_exp) begin
          errors++;
          $display("FAIL flags: got %b required %b", {sleep_out, display_on, inverted}, flag_exp);
        end
      end
      if (byte_valid) begin
        checks++;
        if (byte_q.size() == 0) begin
          errors++; $display("FAIL byte_unexpected: got %h, none expected", byte_data);
        end else begin
          be_m = byte_q.pop_front();
          if (byte_data != be_m.data || byte_is_cmd != be_m.is_cmd) begin
            errors++;
            $display("FAIL byte: got %h cmd=%b required %h cmd=%b", byte_data, byte_is_cmd,
                     be_m.data, be_m.is_cmd);
          end
          flag_exp  = be_m.flags;
          flag_pend = 1;
        end
      end
      if (pix_valid) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++; $display("FAIL pix_unexpected: got (%0d,%0d) %h, none expected", pix_x, pix_y, pix_color);
        end else begin
          pe_m = pix_q.pop_front();
          if (pix_x != pe_m.x || pix_y != pe_m.y) begin
            errors++;
            $display("FAIL pix_pos: got (%0d,%0d) required (%0d,%0d)", pix_x, pix_y, pe_m.x, pe_m.y);
          end
          checks++;
          if (pix_color != pe_m.color) begin
            errors++; $display("FAIL pix_color: got %h required %h", pix_color, pe_m.color);
          end
          checks++;
          if (pix_in_view != pe_m.in_view) begin
            errors++; $display("FAIL pix_in_view: got %b required %b", pix_in_view, pe_m.in_view);
          end
          checks++;
          if (frame_done != pe_m.fd) begin
            errors++; $display("FAIL frame_done: got %b required %b at (%0d,%0d)", frame_done, pe_m.fd, pix_x, pix_y);
          end
        end
      end else if (frame_done) begin
        checks++;
        errors++; $display("FAIL frame_done_alone: got 1 required 0 without pix_valid");
      end
    end
  end

endmodule
